// File: rtl/fetch_pkg.sv
// Shared fetch-path types for the PC redirect controller.
//   state_t     : controller FSM states (RUN, PEND, DRAIN)
//   redir_cls_t : redirect class; numeric order equals priority, so a plain
//                 magnitude compare decides replacement
//   PC_INC      : sequential fetch increment in bytes
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_JMP  = 2'd1,
    CLS_BR   = 2'd2,
    CLS_EXC  = 2'd3
  } redir_cls_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/redirect_arbiter.sv
// Combinational priority select among the three redirect sources.
//   exc > br > jmp; a jump is ignored while a load-use stall is active
//   because the ID-stage instruction that produced it is not yet valid.
// Ports:
//   hazard_stall            : load-use stall (masks jmp only)
//   exc_valid/exc_vector    : exception request and vector
//   br_valid/br_target      : EX-stage taken branch
//   jmp_valid/jmp_target    : ID-stage jump
//   o_cls / o_target        : winning class (CLS_NONE if none) and its target
module redirect_arbiter
  import fetch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         hazard_stall,
  input  logic         exc_valid,
  input  logic [W-1:0] exc_vector,
  input  logic         br_valid,
  input  logic [W-1:0] br_target,
  input  logic         jmp_valid,
  input  logic [W-1:0] jmp_target,
  output redir_cls_t   o_cls,
  output logic [W-1:0] o_target
);

  always_comb begin
    o_cls    = CLS_NONE;
    o_target = '0;
    if (exc_valid) begin
      o_cls    = CLS_EXC;
      o_target = exc_vector;
    end else if (br_valid) begin
      o_cls    = CLS_BR;
      o_target = br_target;
    end else if (jmp_valid && !hazard_stall) begin
      o_cls    = CLS_JMP;
      o_target = jmp_target;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-sequencing controller for the program counter register.
// Chooses each cycle between a redirect (exc/br/jmp) and sequential fetch,
// parks a redirect that arrives while instruction memory is busy, and
// produces IF/ID and ID/EX flushes.
// Handshake: a redirect source is sampled only in the cycle its *_valid is
// high; there is no ready back to the source. Once captured it is held here
// until applied, so the source need not keep it asserted.
// Ports:
//   clk, rst                : clock, async active-high reset
//   pc                      : current PC (PC register Q)
//   hazard_stall, mem_busy  : stall inputs
//   exc_*/br_*/jmp_*        : redirect sources
//   pc_write, next_pc       : PC register enable / D (combinational)
//   flush_if_id/flush_id_ex : pipeline squashes (combinational)
//   redirect_pending        : registered, high while in PEND
//   redirect_cnt            : saturating count of applied redirects
//   state_dbg               : current FSM state for observation
module pc_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter int           CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     pc,
  input  logic             hazard_stall,
  input  logic             mem_busy,
  input  logic             exc_valid,
  input  logic [W-1:0]     exc_vector,
  input  logic             br_valid,
  input  logic [W-1:0]     br_target,
  input  logic             jmp_valid,
  input  logic [W-1:0]     jmp_target,
  output logic             pc_write,
  output logic [W-1:0]     next_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] redirect_cnt,
  output state_t           state_dbg
);

  state_t           r_state;
  redir_cls_t       r_pend_cls;
  logic [W-1:0]     r_pend_tgt;
  logic [CNT_W-1:0] r_cnt;

  redir_cls_t   w_req_cls;
  logic [W-1:0] w_req_tgt;
  logic [W-1:0] w_seq_pc;

  state_t       w_state_nxt;
  redir_cls_t   w_pend_cls_nxt;
  logic [W-1:0] w_pend_tgt_nxt;
  logic         w_apply;
  redir_cls_t   w_sel_cls;
  logic [W-1:0] w_sel_tgt;
  logic         w_pc_write;
  logic [W-1:0] w_next_pc;
  logic         w_flush_if_id;
  logic         w_flush_id_ex;

  redirect_arbiter #(.W(W)) u_arb (
    .hazard_stall (hazard_stall),
    .exc_valid    (exc_valid),
    .exc_vector   (exc_vector),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .o_cls        (w_req_cls),
    .o_target     (w_req_tgt)
  );

  // Sequential PC wraps silently modulo 2^W.
  assign w_seq_pc = pc + W'(PC_INC);

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_cls_nxt = r_pend_cls;
    w_pend_tgt_nxt = r_pend_tgt;
    w_apply        = 1'b0;
    w_sel_cls      = CLS_NONE;
    w_sel_tgt      = w_seq_pc;
    w_pc_write     = 1'b0;
    w_next_pc      = w_seq_pc;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;

    if (r_state == ST_PEND) begin
      // Only a strictly higher class displaces the parked redirect.
      if (w_req_cls > r_pend_cls) begin
        w_sel_cls = w_req_cls;
        w_sel_tgt = w_req_tgt;
      end else begin
        w_sel_cls = r_pend_cls;
        w_sel_tgt = r_pend_tgt;
      end
      if (!mem_busy) begin
        w_apply = 1'b1;
      end else begin
        w_pend_cls_nxt = w_sel_cls;
        w_pend_tgt_nxt = w_sel_tgt;
      end
    end else begin
      // RUN and DRAIN share behaviour; DRAIN also kills the stale fetch.
      w_flush_if_id = (r_state == ST_DRAIN);
      w_state_nxt   = ST_RUN;
      w_sel_cls     = w_req_cls;
      w_sel_tgt     = w_req_tgt;
      if (w_req_cls != CLS_NONE) begin
        if (!mem_busy) begin
          w_apply = 1'b1;
        end else begin
          w_pend_cls_nxt = w_req_cls;
          w_pend_tgt_nxt = w_req_tgt;
          w_state_nxt    = ST_PEND;
        end
      end else begin
        w_pc_write = !(hazard_stall || mem_busy);
      end
    end

    if (w_apply) begin
      w_pc_write     = 1'b1;
      w_next_pc      = w_sel_tgt;
      w_flush_if_id  = 1'b1;
      w_flush_id_ex  = (w_sel_cls == CLS_EXC) || (w_sel_cls == CLS_BR);
      w_pend_cls_nxt = CLS_NONE;
      w_pend_tgt_nxt = '0;
      w_state_nxt    = ST_DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pend_cls <= CLS_NONE;
      r_pend_tgt <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_cls <= w_pend_cls_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      if (w_apply && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  assign pc_write         = rst ? 1'b0 : w_pc_write;
  assign next_pc          = rst ? RESET_PC : w_next_pc;
  assign flush_if_id      = rst ? 1'b0 : w_flush_if_id;
  assign flush_id_ex      = rst ? 1'b0 : w_flush_id_ex;
  assign redirect_pending = (r_state == ST_PEND);
  assign redirect_cnt     = r_cnt;
  assign state_dbg        = r_state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;
  import fetch_pkg::*;

  localparam int W     = 32;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]     pc;
  logic             hazard_stall, mem_busy;
  logic             exc_valid, br_valid, jmp_valid;
  logic [W-1:0]     exc_vector, br_target, jmp_target;
  logic             pc_write, flush_if_id, flush_id_ex, redirect_pending;
  logic [W-1:0]     next_pc;
  logic [CNT_W-1:0] redirect_cnt;
  state_t           state_dbg;

  int n_vec  = 0;
  int n_fail = 0;

  pc_redirect_ctrl #(.W(W), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .hazard_stall     (hazard_stall),
    .mem_busy         (mem_busy),
    .exc_valid        (exc_valid),
    .exc_vector       (exc_vector),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .jmp_valid        (jmp_valid),
    .jmp_target       (jmp_target),
    .pc_write         (pc_write),
    .next_pc          (next_pc),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .redirect_pending (redirect_pending),
    .redirect_cnt     (redirect_cnt),
    .state_dbg        (state_dbg)
  );

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; outputs are sampled 1ns later,
  // well away from the rising edge.
  task automatic drive(input logic e, input logic [W-1:0] ev,
                       input logic b, input logic [W-1:0] bt,
                       input logic j, input logic [W-1:0] jt,
                       input logic st, input logic bsy, input logic [W-1:0] p);
    exc_valid = e;  exc_vector = ev;
    br_valid  = b;  br_target  = bt;
    jmp_valid = j;  jmp_target = jt;
    hazard_stall = st; mem_busy = bsy; pc = p;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pw, input logic [W-1:0] npc,
                         input logic fi, input logic fe);
    chk({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, pw});
    chk({tag, ".next_pc"}, next_pc, npc);
    chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fi});
    chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, fe});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive(1'b1, 32'h80, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h100);
    // Reset state, with an exception present that must be ignored.
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset.pending", {31'd0, redirect_pending}, 32'd0);
    chk("reset.cnt", {16'd0, redirect_cnt}, 32'd0);
    chk("reset.state", {30'd0, state_dbg}, {30'd0, ST_RUN});

    next_cycle(); rst = 1'b0;
    // Sequential fetch.
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h100);
    chk_out("seq", 1'b1, 32'h104, 1'b0, 1'b0);
    drive(0, '0, 0, '0, 0, '0, 1, 0, 32'h100);
    chk_out("seq_stall", 1'b0, 32'h104, 1'b0, 1'b0);

    // Branch during load-use stall.
    drive(0, '0, 1, 32'h200, 0, '0, 1, 0, 32'h100);
    chk_out("br_stall", 1'b1, 32'h200, 1'b1, 1'b1);
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h200);
    chk_out("br_drain", 1'b1, 32'h204, 1'b1, 1'b0);
    chk("br_drain.cnt", {16'd0, redirect_cnt}, 32'd1);
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h204);
    chk_out("br_run", 1'b1, 32'h208, 1'b0, 1'b0);

    // Branch while memory busy for 3 cycles.
    drive(0, '0, 1, 32'h300, 0, '0, 0, 1, 32'h204);
    chk_out("busy_c0", 1'b0, 32'h208, 1'b0, 1'b0);
    chk("busy_c0.pending", {31'd0, redirect_pending}, 32'd0);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 0, 1, 32'h204);
      chk($sformatf("busy_c%0d.pc_write", c), {31'd0, pc_write}, 32'd0);
      chk($sformatf("busy_c%0d.pending", c), {31'd0, redirect_pending}, 32'd1);
    end
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h204);
    chk("busy_c3.pending", {31'd0, redirect_pending}, 32'd1);
    chk_out("busy_apply", 1'b1, 32'h300, 1'b1, 1'b1);
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h300);
    chk("busy_after.pending", {31'd0, redirect_pending}, 32'd0);
    chk_out("busy_drain", 1'b1, 32'h304, 1'b1, 1'b0);
    chk("busy_after.cnt", {16'd0, redirect_cnt}, 32'd2);
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h304);
    chk_out("busy_once", 1'b1, 32'h308, 1'b0, 1'b0);

    // Replacement in PEND: jmp parked, exc replaces, later br dropped.
    drive(0, '0, 0, '0, 1, 32'h400, 0, 1, 32'h304);
    chk("repl_c0.pc_write", {31'd0, pc_write}, 32'd0);
    next_cycle();
    drive(1, 32'h80, 0, '0, 0, '0, 0, 1, 32'h304);
    chk("repl_c1.pending", {31'd0, redirect_pending}, 32'd1);
    chk("repl_c1.pc_write", {31'd0, pc_write}, 32'd0);
    next_cycle();
    drive(0, '0, 1, 32'h500, 0, '0, 0, 1, 32'h304);
    chk("repl_c2.pc_write", {31'd0, pc_write}, 32'd0);
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h304);
    chk_out("repl_apply", 1'b1, 32'h80, 1'b1, 1'b1);
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h80);
    chk_out("repl_drain", 1'b1, 32'h84, 1'b1, 1'b0);
    chk("repl.cnt", {16'd0, redirect_cnt}, 32'd3);

    // Jump in DRAIN: applied, only IF/ID flushed.
    drive(0, '0, 0, '0, 1, 32'h600, 0, 0, 32'h80);
    chk_out("jmp", 1'b1, 32'h600, 1'b1, 1'b0);
    next_cycle();
    // Jump masked by load-use stall.
    drive(0, '0, 0, '0, 1, 32'h700, 1, 0, 32'h600);
    chk_out("jmp_stall", 1'b0, 32'h604, 1'b1, 1'b0);
    chk("jmp.cnt", {16'd0, redirect_cnt}, 32'd4);
    next_cycle();

    // Simultaneous sources: exc wins, nothing replayed afterwards.
    drive(1, 32'h80, 1, 32'h200, 1, 32'h400, 0, 0, 32'h604);
    chk_out("simul", 1'b1, 32'h80, 1'b1, 1'b1);
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h80);
    chk_out("simul_after", 1'b1, 32'h84, 1'b1, 1'b0);
    chk("simul.cnt", {16'd0, redirect_cnt}, 32'd5);
    next_cycle();

    // Reset mid-PEND.
    drive(0, '0, 1, 32'h700, 0, '0, 0, 1, 32'h84);
    next_cycle();
    drive(0, '0, 0, '0, 0, '0, 0, 1, 32'h84);
    chk("rstpend.pending_before", {31'd0, redirect_pending}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstpend.pending", {31'd0, redirect_pending}, 32'd0);
    chk_out("rstpend", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstpend.cnt", {16'd0, redirect_cnt}, 32'd0);
    next_cycle(); rst = 1'b0;
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'h100);
    chk_out("rstpend_after", 1'b1, 32'h104, 1'b0, 1'b0);

    // Wrap at the top of the address space.
    drive(0, '0, 0, '0, 0, '0, 0, 0, 32'hFFFF_FFFC);
    chk_out("wrap", 1'b1, 32'h0, 1'b0, 1'b0);

    // Saturation: one branch applied every cycle.
    drive(0, '0, 1, 32'h10, 0, '0, 0, 0, 32'h10);
    repeat (65540) next_cycle();
    chk("sat.cnt", {16'd0, redirect_cnt}, 32'h0000_FFFF);
    next_cycle();
    chk("sat_hold.cnt", {16'd0, redirect_cnt}, 32'h0000_FFFF);
    chk_out("sat_apply", 1'b1, 32'h10, 1'b1, 1'b1);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-sequencing controller for the program counter register. Each cycle it picks one of three redirect sources (exception, EX-stage taken branch, ID-stage jump) or sequential fetch, and drives the PC register's write enable and D input. It holds a redirect that arrives while instruction memory is busy, so redirects are never lost or applied twice, and it emits pipeline flushes for the IF/ID and ID/EX registers. It sits between the hazard unit, branch/jump resolution logic and the PC register; all PC-update decisions live in this block.

## Interface
- W, 32, address width
- RESET_PC, 32'h0000_0000, value of next_pc while rst is asserted
- CNT_W, 16, width of the saturating redirect counter

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  W  current PC (PC register Q)
- hazard_stall  in  1  load-use stall from hazard unit
- mem_busy  in  1  instruction memory not ready; fetch frozen
- exc_valid / exc_vector  in  1 / W  exception redirect, highest priority
- br_valid / br_target  in  1 / W  taken branch resolved in EX
- jmp_valid / jmp_target  in  1 / W  jump resolved in ID, lowest priority
- pc_write  out  1  PC register enable
- next_pc  out  W  PC register D
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register
- redirect_pending  out  1  a captured redirect is waiting
- redirect_cnt  out  CNT_W  applied-redirect count, saturates at all-ones

## Operation
- Source priority: exc > br > jmp. jmp_valid is ignored while hazard_stall=1.
- States:
  - RUN: normal fetch.
  - PEND: redirect captured; waiting for mem_busy=0.
  - DRAIN: one cycle after a redirect is applied.
- RUN, no request:
  - pc_write = !(hazard_stall | mem_busy).
  - next_pc = pc+4, modulo 2^W; wrap at all-ones is silent.
- RUN, request, mem_busy=0: apply it.
  - hazard_stall does not block exc or br, because the stalled instruction is wrong-path.
  - pc_write=1, next_pc=target.
  - Go to DRAIN.
- RUN, request, mem_busy=1:
  - Latch the winning target and its class into the pending register.
  - pc_write=0; go to PEND.
- PEND:
  - A new request of strictly higher priority than the pending class replaces it. Equal or lower priority is dropped, since it is younger wrong-path work.
  - When mem_busy=0, apply the pending target (or its same-cycle replacement), clear pending, go to DRAIN.
- Flushes on the apply cycle:
  - exc or br: flush_if_id=1 and flush_id_ex=1.
  - jmp: flush_if_id=1 only.
- DRAIN:
  - flush_if_id=1 again, to kill the fetch issued with the old PC that is still in flight.
  - Otherwise behaves as RUN, including accepting a new redirect, which takes a fresh DRAIN.
  - Returns to RUN after one cycle.
- redirect_cnt increments by 1 on every apply cycle and holds at 2^CNT_W-1.

## Timing
- Reset values while rst=1:
  - state=RUN, pending cleared, redirect_cnt=0.
  - pc_write=0, next_pc=RESET_PC.
  - flush_if_id=0, flush_id_ex=0, redirect_pending=0.
- Outputs pc_write, next_pc and flushes are combinational from state, pending register and current inputs. This is zero-latency: the PC holds the target at the next rising edge.
- redirect_pending is registered: 1 from the edge that enters PEND until the edge that leaves it.
- Reset asserted mid-PEND or mid-DRAIN discards the pending redirect immediately.
- Simultaneous exc, br and jmp in RUN with mem_busy=0: only exc is applied; br and jmp are discarded.

## Structure
- Shared package (fetch_pkg) holds:
  - the state enum {RUN, PEND, DRAIN};
  - the redirect-class enum {NONE, JMP, BR, EXC}, encoded so numeric order equals priority;
  - the PC increment constant 4.
- One sub-module, redirect_arbiter: combinational priority select of class and target from the three sources.
- Pending and state flops reuse the team's REGISTER primitive where enable semantics fit.

## Test plan
- Sequential fetch: reset, pc=0x100, no requests → next_pc=0x104, pc_write=1, both flushes 0.
- Branch during load-use stall: hazard_stall=1, br_valid=1, br_target=0x200 → same cycle pc_write=1, next_pc=0x200, both flushes=1; next cycle flush_if_id=1 only; redirect_cnt=1.
- Branch while memory busy: mem_busy=1 for 3 cycles, br_target=0x300 in cycle 0, then mem_busy=0 → redirect_pending=1 for 3 cycles, pc_write=0 throughout, then next_pc=0x300 applied once.
- Replacement in PEND: pending jmp 0x400, then exc_vector=0x80 while still busy → 0x80 applied; a later br in PEND is dropped.
- Simultaneous sources: exc 0x80, br 0x200, jmp 0x400 with mem_busy=0 → next_pc=0x80, flush_id_ex=1.
- Reset mid-PEND, plus wrap and saturation: rst pulse while pending → redirect_pending=0 and next_pc=RESET_PC immediately. Separately, pc=0xFFFF_FFFC → next_pc=0x0. Force 2^16 redirects → redirect_cnt=0xFFFF and holds.
